// File: rtl/mmm_serial_core.sv
// Bit-serial Montgomery multiplier: result = A * B * 2^(-WIDTH) mod M.
// One multiplier bit is consumed per enabled cycle, then a single conditional subtraction is applied.
//
// state     | meaning
// ----------|-----------------------------------------------
// S_IDLE    | waiting for start, accumulator cleared
// S_ITER    | WIDTH shift-add-reduce iterations
// S_CORRECT | final conditional subtraction of M
// S_DONE    | result valid, done held high
module mmm_serial_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITER    = 2'd1,
        S_CORRECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_reg;

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_odd;
    logic [WIDTH+1:0] acc_next;
    logic             acc_ge_m;
    logic [WIDTH-1:0] acc_corr;

    // acc stays below 2M, so acc + B + M fits in WIDTH+2 bits.
    always_comb begin
        t_add    = acc + (a_reg[0] ? {2'b00, b_reg} : '0);
        t_odd    = t_add + (t_add[0] ? {2'b00, m_reg} : '0);
        acc_next = t_odd >> 1;
        acc_ge_m = (acc >= {2'b00, m_reg});
        acc_corr = acc_ge_m ? (acc[WIDTH-1:0] - m_reg) : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            m_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            res_reg <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state <= S_IDLE;
                acc   <= '0;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            a_reg <= a_in;
                            b_reg <= b_in;
                            m_reg <= m_in;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= S_ITER;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    S_ITER: begin
                        acc   <= acc_next;
                        a_reg <= a_reg >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= S_CORRECT;
                        end
                    end
                    S_CORRECT: begin
                        res_reg <= acc_corr;
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result = res_reg;

endmodule

// File: tb/tb_mmm_serial_core.sv
// Randomised self-checking bench for mmm_serial_core (WIDTH=8).
// Expected products come from a brute-force modular-inverse search, not from the shift-add recurrence.
module tb_mmm_serial_core;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstb;
    logic             ena;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] m_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    mmm_serial_core #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .clear  (clear),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .m_in   (m_in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // x such that x * 2^WIDTH == a * b (mod m)
    function automatic int mont_ref(input int a, input int b, input int m);
        int p;
        p = (a * b) % m;
        for (int x = 0; x < m; x++) begin
            if (((x * (1 << WIDTH)) % m) == p) return x;
        end
        return -1;
    endfunction

    // Accept a start, then wait for done. lat counts enabled edges after the accept edge,
    // busy_n counts post-enabled-edge samples with busy=1 (including the accept edge).
    task automatic do_mult(input int a, input int b, input int m, input bit rand_ena,
                           output int lat, output int busy_n, output int res);
        bit en_this;
        ena   = 1'b1;
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        m_in  = WIDTH'(m);
        start = 1'b1;
        tick();
        start  = 1'b0;
        a_in   = WIDTH'($urandom);
        b_in   = WIDTH'($urandom);
        m_in   = WIDTH'($urandom);
        lat    = -1;
        busy_n = busy ? 1 : 0;
        for (int i = 0, n = 0; i < 200; i++) begin
            ena     = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
            en_this = ena;
            tick();
            if (en_this) begin
                n++;
                if (busy) busy_n++;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        ena = 1'b1;
        res = int'(result);
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; clear = 1'b0; start = 1'b0;
        a_in = '0; b_in = '0; m_in = '0;
        tick(); tick();
        rstb = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, result} !== {1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0b done=%0b result=%0d, want 0/0/0", busy, done, result);
        end
    endtask

    task automatic test_basic();
        int lat, bn, res;
        do_mult(5, 7, 13, 1'b0, lat, bn, res);
        n_cmp++;
        if (lat != 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        n_cmp++;
        if (bn != 9) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 9", bn); end
        n_cmp++;
        if (res != 1) begin n_bad++; $display("FAIL basic_result: got %0d want 1", res); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_done: got %0b want 0", busy); end
        tick(); tick();
        n_cmp++;
        if ({done, result} !== {1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL basic_done_hold: done=%0b result=%0d want 1/1", done, result);
        end
    endtask

    task automatic test_correct_path();
        int lat, bn, res;
        do_mult(250, 250, 251, 1'b0, lat, bn, res);
        n_cmp++;
        if (res != 201 || lat != 9) begin
            n_bad++; $display("FAIL correct_sub: result=%0d lat=%0d want 201/9", res, lat);
        end
        // restart straight from DONE
        ena = 1'b1; a_in = 8'd0; b_in = 8'd77; m_in = 8'd251; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({done, busy} !== 2'b01) begin
            n_bad++; $display("FAIL restart_from_done: done=%0b busy=%0b want 0/1", done, busy);
        end
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        n_cmp++;
        if (lat != 9 || result !== 8'd0) begin
            n_bad++; $display("FAIL restart_result: result=%0d lat=%0d want 0/9", result, lat);
        end
    endtask

    task automatic test_stall();
        logic [9:0] snap;
        int lat;
        ena = 1'b1; a_in = 8'd5; b_in = 8'd7; m_in = 8'd13; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        snap = {busy, done, result};
        ena  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; a_in = WIDTH'($urandom);
            tick();
            n_cmp++;
            if ({busy, done, result} !== snap) begin
                n_bad++;
                $display("FAIL stall_frozen: got %h want %h at stall %0d", {busy, done, result}, snap, i);
            end
        end
        start = 1'b0;
        ena   = 1'b1;
        lat   = -1;
        for (int i = 9; i <= 60; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        n_cmp++;
        if (lat != 14 || result !== 8'd1) begin
            n_bad++; $display("FAIL stall_result: edges=%0d result=%0d want 14/1", lat, result);
        end
    endtask

    task automatic test_abort();
        int lat, bn, res;
        ena = 1'b1; a_in = 8'd5; b_in = 8'd7; m_in = 8'd13; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL abort_iter: busy=%0b done=%0b want 0/0", busy, done);
        end
        tick(); tick(); tick(); tick(); tick(); tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL abort_stays_idle: busy=%0b done=%0b want 0/0", busy, done);
        end
        a_in = 8'd3; b_in = 8'd4; m_in = 8'd11; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++; $display("FAIL clear_beats_start: busy=%0b done=%0b want 0/0", busy, done);
        end
        do_mult(250, 250, 251, 1'b0, lat, bn, res);
        n_cmp++;
        if (res != 201 || lat != 9) begin
            n_bad++; $display("FAIL post_abort_run: result=%0d lat=%0d want 201/9", res, lat);
        end
    endtask

    task automatic test_restart_ignored();
        int lat;
        int busy_drop;
        ena = 1'b1; a_in = 8'd5; b_in = 8'd7; m_in = 8'd13; start = 1'b1;
        tick();
        start     = 1'b0;
        lat       = -1;
        busy_drop = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 3 || i == 4) begin
                start = 1'b1; a_in = 8'd200; b_in = 8'd100; m_in = 8'd251;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin lat = i; break; end
            if (!busy) busy_drop++;
        end
        start = 1'b0;
        n_cmp++;
        if (lat != 9 || result !== 8'd1 || busy_drop != 0) begin
            n_bad++;
            $display("FAIL restart_ignored: lat=%0d result=%0d busy_gaps=%0d want 9/1/0", lat, result, busy_drop);
        end
    endtask

    task automatic test_random();
        int a, b, m, lat, bn, res, exp;
        for (int k = 0; k < 24; k++) begin
            m   = 2 * $urandom_range(1, 127) + 1;
            a   = $urandom_range(0, m - 1);
            b   = $urandom_range(0, m - 1);
            exp = mont_ref(a, b, m);
            do_mult(a, b, m, k[0], lat, bn, res);
            n_cmp++;
            if (res != exp || lat != 9 || bn != 9) begin
                n_bad++;
                $display("FAIL random_%0d: a=%0d b=%0d m=%0d result=%0d lat=%0d busy=%0d want %0d/9/9",
                         k, a, b, m, res, lat, bn, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn, res;
        for (int pass = 0; pass < 2; pass++) begin
            do_mult(250, 250, 251, 1'b0, lat, bn, res);
            ena = 1'b1; a_in = 8'd5; b_in = 8'd7; m_in = 8'd13; start = 1'b1;
            tick();
            start = 1'b0;
            tick(); tick();
            ena  = (pass == 1);
            rstb = 1'b0;
            tick();
            rstb = 1'b1;
            ena  = 1'b1;
            n_cmp++;
            if ({busy, done, result} !== {1'b0, 1'b0, 8'd0}) begin
                n_bad++;
                $display("FAIL reset_mid_ena%0d: busy=%0b done=%0b result=%0d want 0/0/0", pass, busy, done, result);
            end
            tick(); tick();
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_mid_idle_ena%0d: busy=%0b done=%0b want 0/0", pass, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_correct_path();
        test_stall();
        test_abort();
        test_restart_ignored();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmm_serial_core.md
Name: mmm_serial_core

Overview:
- Bit-serial Montgomery modular multiplier datapath that answers the exponentiation control sequencer's requests.
- Computes result = A * B * 2^(-WIDTH) mod M, one multiplier bit per iteration.
- Sits under the RSA control FSM, which drives start/clear and consumes done/result. It is also usable stand-alone.

Parameters:
- WIDTH, 8, operand/modulus width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  reset
- ena  input  1  global clock enable; when 0, all state and registers hold
- clear  input  1  synchronous abort; returns to IDLE and zeroes the accumulator
- start  input  1  request a multiplication; operands are sampled on the accepting edge
- a_in  input  WIDTH  multiplier A; precondition A < M
- b_in  input  WIDTH  multiplicand B; precondition B < M
- m_in  input  WIDTH  modulus M; precondition M odd, M > 1
- busy  output  1  high in ITER and CORRECT states
- done  output  1  high in DONE state (level, not pulse)
- result  output  WIDTH  final product; valid while done=1

Behaviour:
- Reset:
  - rstb is synchronous and active-low: sampled on the clk rising edge, highest priority, independent of ena.
  - On reset: state=IDLE, internal registers=0, busy=0, done=0, result=0.
- Priority per edge: rstb > ena=0 (hold everything) > clear > start > normal operation.
- Internal registers:
  - a_reg, b_reg, m_reg: WIDTH bits each.
  - acc: WIDTH+2 bits, so no overflow.
  - cnt: clog2(WIDTH)+1 bits.
  - res_reg: WIDTH bits.
- IDLE / DONE with start=1 (and ena=1, clear=0):
  - Latch a_in, b_in and m_in; set acc=0 and cnt=0; go to ITER.
  - In DONE, done drops on this edge.
- ITER, one iteration per enabled edge:
  - t = acc + (a_reg[0] ? b_reg : 0).
  - If t is odd, t = t + m_reg.
  - acc = t >> 1; a_reg >>= 1; cnt++.
  - When cnt == WIDTH-1 on the edge, go to CORRECT. ITER therefore lasts exactly WIDTH enabled cycles.
- CORRECT, one cycle:
  - If acc >= m_reg (zero-extended), res_reg = acc - m_reg; otherwise res_reg = acc[WIDTH-1:0].
  - Go to DONE.
- DONE: holds result and done=1 indefinitely until start, clear or reset.
- Latency: the start-accept edge is E0, and done is first high after edge E0+WIDTH+1, counting enabled edges only.
- start while busy: ignored; no restart, and the operands in flight are unchanged.
- clear:
  - In any state, next state is IDLE, acc=0, cnt=0, busy=0, done=0.
  - res_reg is retained, but result remains valid only when done=1.
  - clear and start on the same edge: clear wins and start is dropped.
- ena=0 mid-operation: state, counters and registers freeze; output values stay constant. Resuming continues exactly where it stopped.
- Input changes after the accepting edge have no effect.
- Arithmetic:
  - Pre-correction acc < 2M is guaranteed by the preconditions.
  - Precondition violations produce an undefined but stable result. The FSM must still terminate in DONE after WIDTH+1 cycles.
- The state encoding must be safe: any unreachable state returns to IDLE on the next enabled edge.

Test Plan:
- WIDTH=8, M=13, A=5, B=7; start pulsed for 1 cycle -> done high exactly 9 enabled cycles after the accept edge; result=1; busy high for exactly those 9 cycles.
- M=251, A=250, B=250 -> result=201, which exercises the CORRECT subtraction path. Then start again with A=0, B=77, M=251 from the DONE state -> done drops for one run, then result=0.
- Stall: M=13, A=5, B=7 with ena forced to 0 for 5 cycles mid-ITER -> done is delayed by exactly 5 cycles, result=1, and outputs are frozen during the stall.
- Abort: clear asserted at iteration 4, then in a later run clear and start together -> IDLE, busy=0, done=0 each time. A new start afterwards gives a correct result with no residue from the aborted run.
- start re-pulsed during ITER with different operands -> ignored; original result=1 returned on schedule.
- rstb low mid-operation, with ena=0 and then with ena=1 -> after the next edge, state is IDLE and busy=done=result=0 in both cases.
